// File: rtl/exynos4412_pkg.sv
// Shared definitions for the Exynos4412 CPU supervisor: state encodings and
// tick-domain (100us) timing constants used by the supervisor and its sequencer.
package exynos4412_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_POWERING  = 3'd1,
        ST_BOOTING   = 3'd2,
        ST_RUNNING   = 3'd3,
        ST_FAULT_OFF = 3'd4,
        ST_SHUTDOWN  = 3'd5,
        ST_LOCKOUT   = 3'd6,
        ST_INVALID   = 3'd7
    } sup_state_t;

    localparam int TIMER_W      = 20;
    localparam int PG_TIMEOUT   = 200;     // 20ms
    localparam int BOOT_TIMEOUT = 300000;  // 30s
    localparam int HB_TIMEOUT   = 20000;   // 2s
    localparam int COOLDOWN     = 200;     // 20ms
    localparam int MAX_RETRIES  = 3;

    // The sequencer needs 10ms to take the rails down in order.
    localparam int SEQ_SHUTDOWN_TICKS = 100;

    function automatic bit cooldown_covers_sequencer(input int cooldown_ticks);
        return cooldown_ticks > SEQ_SHUTDOWN_TICKS;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input, plus a third flop that
// turns any change of the synchronized level into a one-cycle pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic edge_pulse
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: non-blocking assignments so each flop samples the previous stage's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level      = sync_q;
    assign edge_pulse = sync_q ^ prev_q;

endmodule

// File: rtl/exynos4412_supervisor.sv
// CPU power supervisor: watches PMIC power-good, heartbeat and shutdown request,
// retries failed power-ups a bounded number of times. Heartbeat supervision is
// built only when EXYNOS_SUPERVISOR_HEARTBEAT_EN is defined.
module exynos4412_supervisor #(
    parameter int TIMER_W      = exynos4412_pkg::TIMER_W,
    parameter int PG_TIMEOUT   = exynos4412_pkg::PG_TIMEOUT,
    parameter int BOOT_TIMEOUT = exynos4412_pkg::BOOT_TIMEOUT,
    parameter int HB_TIMEOUT   = exynos4412_pkg::HB_TIMEOUT,
    parameter int COOLDOWN     = exynos4412_pkg::COOLDOWN,
    parameter int MAX_RETRIES  = exynos4412_pkg::MAX_RETRIES
) (
    input  logic       sysclk,
    input  logic       reset_INV,
    input  logic       tick_100us,
    input  logic       board_enable,
    input  logic       cpu_pmic_pwrgood,
    input  logic       cpu_heartbeat,
    input  logic       cpu_shutdown_req,
    output logic       cpu_enable,
    output logic       cpu_fault,
    output logic [2:0] restart_count,
    output logic [2:0] sup_state
);
    import exynos4412_pkg::*;

    if (!cooldown_covers_sequencer(exynos4412_pkg::COOLDOWN)) begin : g_bad_cooldown
        $error("COOLDOWN must exceed the sequencer shutdown time");
    end

    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRIES);

    sup_state_t         state;
    sup_state_t         next_state;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] limit;
    logic               timeout;
    logic               pg_level;
    logic               sd_level;
    logic               hb_edge;
    logic               stop_req;
    logic               pg_edge_unused;
    logic               sd_edge_unused;

    sync_edge_detect u_pg_sync (
        .clk(sysclk), .rst_n(reset_INV), .async_in(cpu_pmic_pwrgood),
        .level(pg_level), .edge_pulse(pg_edge_unused)
    );

    sync_edge_detect u_sd_sync (
        .clk(sysclk), .rst_n(reset_INV), .async_in(cpu_shutdown_req),
        .level(sd_level), .edge_pulse(sd_edge_unused)
    );

`ifdef EXYNOS_SUPERVISOR_HEARTBEAT_EN
    localparam bit HB_EN = 1'b1;
    logic hb_level_unused;

    sync_edge_detect u_hb_sync (
        .clk(sysclk), .rst_n(reset_INV), .async_in(cpu_heartbeat),
        .level(hb_level_unused), .edge_pulse(hb_edge)
    );
`else
    localparam bit HB_EN = 1'b0;
    logic hb_pin_unused;

    assign hb_pin_unused = cpu_heartbeat;
    assign hb_edge       = 1'b0;
`endif

    always_comb begin
        limit = '0;
        case (state)
            ST_POWERING:              limit = TIMER_W'(PG_TIMEOUT);
            ST_BOOTING:               limit = TIMER_W'(BOOT_TIMEOUT);
            ST_RUNNING:               limit = TIMER_W'(HB_TIMEOUT);
            ST_FAULT_OFF, ST_SHUTDOWN: limit = TIMER_W'(COOLDOWN);
            default:                  limit = '0;
        endcase
    end

    assign timeout  = (timer >= limit);
    assign stop_req = !board_enable || sd_level;

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:
                if (board_enable && !sd_level) next_state = ST_POWERING;
            ST_POWERING:
                if (stop_req)      next_state = ST_SHUTDOWN;
                else if (timeout)  next_state = ST_FAULT_OFF;
                else if (pg_level) next_state = ST_BOOTING;
            ST_BOOTING:
                if (stop_req)                  next_state = ST_SHUTDOWN;
                else if (!HB_EN)               next_state = pg_level ? ST_RUNNING : ST_FAULT_OFF;
                else if (hb_edge)              next_state = ST_RUNNING;  // edge beats a same-cycle timeout
                else if (timeout || !pg_level) next_state = ST_FAULT_OFF;
            ST_RUNNING:
                if (stop_req)                            next_state = ST_SHUTDOWN;
                else if (!pg_level || (HB_EN && timeout)) next_state = ST_FAULT_OFF;
            ST_FAULT_OFF:
                if (timeout) begin
                    if (restart_count > RETRY_LIMIT) next_state = ST_LOCKOUT;
                    else if (board_enable)           next_state = ST_POWERING;
                    else                             next_state = ST_IDLE;
                end
            ST_SHUTDOWN:
                if (timeout) next_state = ST_IDLE;
            ST_LOCKOUT:
                if (!board_enable) next_state = ST_IDLE;
            default:
                next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state         <= ST_IDLE;
            timer         <= '0;
            restart_count <= '0;
            cpu_enable    <= 1'b0;
            cpu_fault     <= 1'b0;
        end else begin
            state <= next_state;

            if (next_state != state || (state == ST_RUNNING && hb_edge)) timer <= '0;
            else if (tick_100us && timer != '1)                          timer <= timer + 1'b1;

            // Cleared on the way into IDLE so the count reads 0 for the whole IDLE stay.
            if (next_state == ST_IDLE)
                restart_count <= '0;
            else if (next_state == ST_FAULT_OFF && state != ST_FAULT_OFF && restart_count != 3'd7)
                restart_count <= restart_count + 3'd1;

            cpu_enable <= (state == ST_POWERING) || (state == ST_BOOTING) || (state == ST_RUNNING);
            cpu_fault  <= (state == ST_LOCKOUT);
        end
    end

    assign sup_state = state;

endmodule

// File: tb/tb_exynos4412_supervisor.sv
// Directed self-checking bench for exynos4412_supervisor with short timeouts and
// a tick every cycle; expectations follow the build's heartbeat macro.
module tb_exynos4412_supervisor;

    logic       sysclk = 1'b0;
    logic       reset_INV = 1'b0;
    logic       tick_100us = 1'b1;
    logic       board_enable = 1'b0;
    logic       cpu_pmic_pwrgood = 1'b0;
    logic       cpu_heartbeat = 1'b0;
    logic       cpu_shutdown_req = 1'b0;
    logic       cpu_enable;
    logic       cpu_fault;
    logic [2:0] restart_count;
    logic [2:0] sup_state;

    int n_checks = 0;
    int n_fail   = 0;

    exynos4412_supervisor #(
        .TIMER_W(20), .PG_TIMEOUT(4), .BOOT_TIMEOUT(8), .HB_TIMEOUT(5),
        .COOLDOWN(3), .MAX_RETRIES(2)
    ) dut (
        .sysclk(sysclk), .reset_INV(reset_INV), .tick_100us(tick_100us),
        .board_enable(board_enable), .cpu_pmic_pwrgood(cpu_pmic_pwrgood),
        .cpu_heartbeat(cpu_heartbeat), .cpu_shutdown_req(cpu_shutdown_req),
        .cpu_enable(cpu_enable), .cpu_fault(cpu_fault),
        .restart_count(restart_count), .sup_state(sup_state)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (sup_state != target && n < budget);
    endtask

    int  n;
    bit  held;

    initial begin
        // Reset state
        step(2);
        check("rst_state", 32'(sup_state), 0);
        check("rst_enable", 32'(cpu_enable), 0);
        check("rst_fault", 32'(cpu_fault), 0);
        check("rst_count", 32'(restart_count), 0);
        #3 reset_INV = 1'b1;
        step(1);

        // Normal boot
        board_enable = 1'b1;
        step(1);
        check("boot_powering", 32'(sup_state), 1);
        check("boot_enable_lag", 32'(cpu_enable), 0);
        step(1);
        check("boot_enable_on", 32'(cpu_enable), 1);
        cpu_pmic_pwrgood = 1'b1;
        step(3);
        check("boot_booting", 32'(sup_state), 2);
        held = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i % 3 == 0) cpu_heartbeat = ~cpu_heartbeat;
            step(1);
            held &= cpu_enable;
        end
        check("run_state", 32'(sup_state), 3);
        check("run_enable_held", 32'(held), 1);
        check("run_count", 32'(restart_count), 0);

        // Hung CPU (heartbeat build) or lost power-good (default build)
`ifdef EXYNOS_SUPERVISOR_HEARTBEAT_EN
        cpu_heartbeat = ~cpu_heartbeat;
        wait_state(3'd4, 30, n);
        check("hung_latency", 32'(n), 9);
`else
        cpu_pmic_pwrgood = 1'b0;
        wait_state(3'd4, 30, n);
        check("pgfail_latency", 32'(n), 3);
        cpu_pmic_pwrgood = 1'b1;
`endif
        check("fault_count", 32'(restart_count), 1);
        check("fault_enable_lag", 32'(cpu_enable), 1);
        step(1);
        check("fault_enable_off", 32'(cpu_enable), 0);
        step(3);
        check("retry_powering", 32'(sup_state), 1);
        check("retry_enable_lag", 32'(cpu_enable), 0);
        step(1);
        check("retry_enable_on", 32'(cpu_enable), 1);
        check("retry_booting", 32'(sup_state), 2);
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) cpu_heartbeat = ~cpu_heartbeat;
            step(1);
        end
        check("retry_running", 32'(sup_state), 3);

        // Shutdown request
        cpu_shutdown_req = 1'b1;
        step(3);
        check("sd_state", 32'(sup_state), 5);
        check("sd_enable_lag", 32'(cpu_enable), 1);
        check("sd_count_kept", 32'(restart_count), 1);
        step(1);
        check("sd_enable_off", 32'(cpu_enable), 0);
        cpu_pmic_pwrgood = 1'b0;
        step(2);
        check("sd_cooldown", 32'(sup_state), 5);
        step(1);
        check("sd_idle", 32'(sup_state), 0);
        check("sd_idle_count", 32'(restart_count), 0);
        step(3);
        check("idle_hold_req", 32'(sup_state), 0);
        cpu_shutdown_req = 1'b0;
        step(2);
        check("idle_release_wait", 32'(sup_state), 0);
        step(1);
        check("idle_restart", 32'(sup_state), 1);

        // Lockout: power-good never rises
        wait_state(3'd6, 60, n);
        check("lock_latency", 32'(n), 27);
        check("lock_count", 32'(restart_count), 3);
        check("lock_enable", 32'(cpu_enable), 0);
        step(1);
        check("lock_fault", 32'(cpu_fault), 1);
        check("lock_hold", 32'(sup_state), 6);
        board_enable = 1'b0;
        cpu_pmic_pwrgood = 1'b1;
        step(1);
        check("unlock_idle", 32'(sup_state), 0);
        check("unlock_count", 32'(restart_count), 0);
        step(1);
        check("unlock_fault", 32'(cpu_fault), 0);

        // Heartbeat edge coinciding with the boot timeout
        board_enable = 1'b1;
        step(1);
        check("edge_powering", 32'(sup_state), 1);
        step(1);
        check("edge_booting", 32'(sup_state), 2);
`ifdef EXYNOS_SUPERVISOR_HEARTBEAT_EN
        step(6);
        cpu_heartbeat = ~cpu_heartbeat;
        step(2);
        check("edge_at_limit", 32'(sup_state), 2);
        step(1);
        check("edge_wins", 32'(sup_state), 3);
`else
        step(1);
        check("boot_skip", 32'(sup_state), 3);
`endif

        // Reset mid-operation
        step(1);
        check("pre_reset_enable", 32'(cpu_enable), 1);
        #3 reset_INV = 1'b0;
        #1;
        check("async_enable", 32'(cpu_enable), 0);
        check("async_state", 32'(sup_state), 0);
        #2 reset_INV = 1'b1;
        #1;
        check("release_state", 32'(sup_state), 0);
        check("release_count", 32'(restart_count), 0);
        check("release_fault", 32'(cpu_fault), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
